// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction size and default reset vector.
package fetch_pkg;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: imem request/response plus the decode-facing instruction handshake.
interface fetch_sequencer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );
endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC select: redirect (word-aligned) beats sequential advance, otherwise hold.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next,
  output logic            misalign
);
  always_comb begin
    pc_next = pc;
    if (redirect_valid)
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    else if (advance)
      pc_next = pc + XLEN'(INSTR_BYTES);
  end

  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, keeps one imem request in flight, holds the fetched word for decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int          XLEN         = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  fetch_sequencer_if.master        bus,
  output logic [XLEN-1:0]          pc_out,
  output logic                     misalign_err
);
  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_data_q, instr_data_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            misalign_q, misalign_d;
  logic            advance;
  logic [2:0]      resume;

  assign resume = halt ? S_IDLE : S_REQ;

  fetch_pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc             (pc_q),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_next        (pc_d),
    .misalign       (misalign_d)
  );

  always_comb begin
    state_d      = state_q;
    instr_data_d = instr_data_q;
    instr_pc_d   = instr_pc_q;
    advance      = 1'b0;
    case (state_q)
      S_IDLE: state_d = resume;
      // A redirect in the accept cycle still lets the old address go out; its data must be dropped.
      S_REQ:  if (bus.imem_req_ready) state_d = redirect_valid ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (redirect_valid)
          state_d = bus.imem_rsp_valid ? resume : S_DROP;
        else if (bus.imem_rsp_valid) begin
          advance      = 1'b1;
          instr_data_d = bus.imem_rsp_data;
          instr_pc_d   = pc_q;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: if (redirect_valid || bus.instr_ready) state_d = resume;
      // The stale response is consumed even if a redirect lands on the same cycle, else nothing would come.
      S_DROP: if (bus.imem_rsp_valid) state_d = resume;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_data_q <= instr_data_d;
      instr_pc_q   <= instr_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = (state_q == S_HOLD);
  assign bus.instr_data     = instr_data_q;
  assign bus.instr_pc       = instr_pc_q;
  assign pc_out             = pc_q;
  assign misalign_err       = misalign_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + random bench for fetch_sequencer against a transaction-level fetch model.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc_out;
  logic        misalign_err;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master),
    .pc_out         (pc_out),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int lat      = 0;
  bit stray_en = 1'b0;

  // model: fetch PC, one outstanding request (live until a redirect), one held instruction
  logic [31:0] m_pc, m_aaddr, m_hpc;
  bit          m_out, m_live, m_held, m_mis;
  int          m_age;
  logic [31:0] q_acc[$];
  logic [31:0] q_del[$];
  int          q_dcyc[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_pc = 32'h0; m_aaddr = 32'h0; m_hpc = 32'h0;
    m_out = 0; m_live = 0; m_held = 0; m_mis = 0; m_age = 0;
  endtask

  task automatic cyc(input bit rdy, input bit ir, input bit rv, input logic [31:0] rpc, input bit h);
    bit sv, iv, rsp, acc, dlv;
    logic [31:0] addr, ipc;
    sv = bus.imem_req_valid; iv = bus.instr_valid;
    addr = bus.imem_req_addr; ipc = bus.instr_pc;
    chk("pc_out", pc_out, m_pc);
    chk("misalign", {31'b0, misalign_err}, {31'b0, m_mis});
    chk("instr_valid", {31'b0, iv}, {31'b0, m_held});
    if (m_held) begin
      chk("instr_pc", ipc, m_hpc);
      chk("instr_data", bus.instr_data, mem(m_hpc));
    end
    if (m_out || m_held) chk("one_outstanding", {31'b0, sv}, 32'd0);
    if (sv) chk("req_addr", addr, m_pc);
    rsp = m_out ? (m_age >= lat) : (stray_en && $urandom_range(0, 3) == 0);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = m_out ? mem(m_aaddr) : $urandom();
    bus.instr_ready    = ir;
    redirect_valid     = rv;
    redirect_pc        = rpc;
    halt               = h;
    @(posedge clk);
    cyc_n++;
    acc = sv && rdy;
    dlv = m_out && rsp && m_live && !rv;
    if (iv && ir) begin q_del.push_back(ipc); q_dcyc.push_back(cyc_n); end
    if (acc) q_acc.push_back(addr);
    if (m_held && (rv || ir)) m_held = 0;
    if (dlv) begin m_held = 1; m_hpc = m_aaddr; end
    if (m_out && rsp) m_out = 0;
    else if (m_out) m_age++;
    if (m_out && rv) m_live = 0;
    if (acc) begin m_out = 1; m_live = !rv; m_age = 0; m_aaddr = m_pc; end
    m_mis = rv && (rpc[1:0] != 2'b00);
    m_pc = rv ? {rpc[31:2], 2'b00} : (dlv ? m_pc + 32'd4 : m_pc);
    @(negedge clk);
  endtask

  task automatic run_until(input int target);
    int k = 0;
    while (q_del.size() < target && k < 40) begin
      cyc(1, 1, 0, 32'd0, 0);
      k++;
    end
    chk("progress", q_del.size(), target);
  endtask

  initial begin
    int n0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.instr_ready = 0;
    mreset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_addr", bus.imem_req_addr, 32'h0);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_instr_data", bus.instr_data, 32'h0);
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
    reset_n = 1'b1;

    // zero-wait sequential fetch: one instruction every 3 cycles
    lat = 0;
    run_until(3);
    chk("acc0", q_acc[0], 32'h0); chk("acc1", q_acc[1], 32'h4); chk("acc2", q_acc[2], 32'h8);
    chk("del0", q_del[0], 32'h0); chk("del1", q_del[1], 32'h4); chk("del2", q_del[2], 32'h8);
    chk("rate01", q_dcyc[1] - q_dcyc[0], 32'd3);
    chk("rate12", q_dcyc[2] - q_dcyc[1], 32'd3);

    // imem back-pressure
    repeat (4) begin
      chk("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      chk("bp_addr", bus.imem_req_addr, 32'hC);
      chk("bp_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
      cyc(0, 1, 0, 32'd0, 0);
    end

    // decode back-pressure
    cyc(1, 1, 0, 32'd0, 0);
    cyc(1, 1, 0, 32'd0, 0);
    repeat (5) begin
      chk("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
      chk("hold_pc", bus.instr_pc, 32'hC);
      chk("hold_data", bus.instr_data, mem(32'hC));
      chk("hold_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
      cyc(1, 0, 0, 32'd0, 0);
    end
    cyc(1, 1, 0, 32'd0, 0);
    chk("del3", q_del[3], 32'hC);

    // redirect while waiting on a slow response
    lat = 2;
    cyc(1, 1, 0, 32'd0, 0);
    cyc(1, 1, 1, 32'h100, 0);
    run_until(5);
    chk("redir_acc", q_acc[5], 32'h100);
    chk("redir_del", q_del[4], 32'h100);

    // misaligned redirect
    lat = 0;
    cyc(0, 1, 1, 32'h202, 0);
    chk("mis_pulse", {31'b0, misalign_err}, 32'd1);
    chk("mis_pc", pc_out, 32'h200);
    cyc(0, 1, 0, 32'd0, 0);
    chk("mis_once", {31'b0, misalign_err}, 32'd0);
    run_until(6);
    chk("mis_acc", q_acc[6], 32'h200);
    chk("mis_del", q_del[5], 32'h200);

    // PC wrap
    cyc(0, 1, 1, 32'hFFFF_FFFC, 0);
    run_until(8);
    chk("wrap_del_top", q_del[6], 32'hFFFF_FFFC);
    chk("wrap_del_zero", q_del[7], 32'h0);
    chk("wrap_acc", q_acc[8], 32'h0);

    // reset while a slow response is outstanding
    lat = 5;
    cyc(1, 1, 0, 32'd0, 0);
    cyc(0, 1, 0, 32'd0, 0);
    reset_n = 1'b0;
    #1;
    chk("mrst_pc", pc_out, 32'h0);
    chk("mrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("mrst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    mreset();
    halt = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    stray_en = 1'b1;
    repeat (4) cyc(1, 1, 0, 32'd0, 1);
    stray_en = 1'b0;
    lat = 0;
    n0 = q_del.size();
    run_until(n0 + 1);
    chk("post_rst_del", q_del[n0], 32'h0);

    // random traffic against the model
    stray_en = 1'b1;
    n0 = q_del.size();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      lat = $urandom_range(0, 3);
      t = $urandom();
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0, t, $urandom_range(0, 7) == 0);
    end
    chk("random_progress", {31'b0, q_del.size() > n0 + 20}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
